// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the APB front-end of the I2C core: register
// offsets, sequencer states, interrupt bit positions and core mode codes.
package i2c_apb_pkg;

  // Register byte offsets
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_ADDR   = 8'h04;
  localparam logic [7:0] REG_CNT    = 8'h08;
  localparam logic [7:0] REG_TXDATA = 8'h0C;
  localparam logic [7:0] REG_RXDATA = 8'h10;
  localparam logic [7:0] REG_STAT   = 8'h14;
  localparam logic [7:0] REG_CMD    = 8'h18;
  localparam logic [7:0] REG_IRQ    = 8'h1C;
  localparam logic [7:0] REG_IRQ_EN = 8'h20;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Interrupt flag bit positions
  localparam int IRQ_DONE      = 0;
  localparam int IRQ_TX_OVF    = 1;
  localparam int IRQ_RX_OVF    = 2;
  localparam int IRQ_TX_UDR    = 3;
  localparam int IRQ_START_ERR = 4;
  localparam int IRQ_W         = 5;

  // Core status bit carrying the per-byte completion handshake
  localparam int STAT_I2C_DONE = 3;

  // CTRL[13:12] mode codes
  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_SLAVE  = 2'b01;
  localparam logic [1:0] MODE_MASTER = 2'b10;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. dout always presents the head entry.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; empty/full come from the reset pointers.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_i2c_regs.sv
// APB3 register front-end for the I2C core: configuration registers,
// TX/RX byte FIFOs, interrupt flags and a per-transfer byte sequencer
// that uses the core's i2c_done status bit as the byte handshake.
module apb_i2c_regs
  import i2c_apb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int APB_AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              i_ready,
  output logic [15:0]       tx_ctrl,
  output logic [7:0]        tx_apb_addr,
  output logic [7:0]        tx_apb_data_cnt,
  output logic [7:0]        data_out_apb,
  input  logic [7:0]        data_in_apb,
  input  logic [7:0]        status,
  output logic              irq
);

  logic access, wr_en, rd_en, busy;
  logic sel_ctrl, sel_addr, sel_cnt, sel_txdata, sel_rxdata;
  logic sel_stat, sel_cmd, sel_irq, sel_irq_en, mapped;

  logic [15:0]      ctrl_q;
  logic [7:0]       addr_q, cnt_q, byte_cnt_q;
  logic [IRQ_W-1:0] irq_q, irq_en_q, irq_set, irq_clr;
  logic             status_done_q, done_pulse;
  state_t           state_q, state_d;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_dout, rx_dout;
  logic       cmd_start, cmd_abort, rw;
  logic       load_dout, clr_cnt, inc_cnt;
  logic       set_done, set_start_err, set_tx_udr;
  logic [8:0] cnt_next;
  logic       unused_pwdata;

  assign access  = psel & penable;
  assign wr_en   = access & pwrite;
  assign rd_en   = access & ~pwrite;
  assign busy    = (state_q != IDLE);
  assign pready  = access;
  assign rw      = addr_q[0];

  assign cmd_start  = wr_en & sel_cmd & pwdata[0];
  assign cmd_abort  = wr_en & sel_cmd & pwdata[1];
  assign tx_push    = wr_en & sel_txdata;
  assign rx_pop     = rd_en & sel_rxdata & ~rx_empty;
  assign done_pulse = status[STAT_I2C_DONE] & ~status_done_q;
  assign cnt_next   = {1'b0, byte_cnt_q} + 9'd1;
  assign i_ready    = (state_q == RUN);
  assign irq        = |(irq_q & irq_en_q);

  assign unused_pwdata = ^pwdata[31:16];

  // Register address decode; misaligned or unknown offsets are unmapped
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    {sel_ctrl, sel_addr, sel_cnt, sel_txdata, sel_rxdata} = '0;
    {sel_stat, sel_cmd, sel_irq, sel_irq_en}              = '0;
    mapped = 1'b1;
    case (paddr)
      APB_AW'(REG_CTRL):   sel_ctrl   = 1'b1;
      APB_AW'(REG_ADDR):   sel_addr   = 1'b1;
      APB_AW'(REG_CNT):    sel_cnt    = 1'b1;
      APB_AW'(REG_TXDATA): sel_txdata = 1'b1;
      APB_AW'(REG_RXDATA): sel_rxdata = 1'b1;
      APB_AW'(REG_STAT):   sel_stat   = 1'b1;
      APB_AW'(REG_CMD):    sel_cmd    = 1'b1;
      APB_AW'(REG_IRQ):    sel_irq    = 1'b1;
      APB_AW'(REG_IRQ_EN): sel_irq_en = 1'b1;
      default:             mapped     = 1'b0;
    endcase
  end

  // Error response: unmapped, empty RX read, config write while busy
  always_comb begin
    pslverr = 1'b0;
    if (access) begin
      pslverr = ~mapped
              | (rd_en & sel_rxdata & rx_empty)
              | (wr_en & busy & (sel_ctrl | sel_addr | sel_cnt));
    end
  end

  // Read data mux, zero outside a read access phase
  always_comb begin
    prdata = '0;
    if (rd_en) begin
      if (sel_ctrl)   prdata = {16'h0, ctrl_q};
      if (sel_addr)   prdata = {24'h0, addr_q};
      if (sel_cnt)    prdata = {24'h0, cnt_q};
      if (sel_rxdata) prdata = rx_empty ? 32'h0 : {24'h0, rx_dout};
      if (sel_stat)   prdata = {16'h0, tx_full, tx_empty, rx_full, rx_empty,
                                busy, 3'b000, status};
      if (sel_irq)    prdata = {27'h0, irq_q};
      if (sel_irq_en) prdata = {27'h0, irq_en_q};
    end
  end

  // Transfer sequencer: next state and per-cycle FIFO/counter actions
  always_comb begin
    state_d       = state_q;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;
    load_dout     = 1'b0;
    clr_cnt       = 1'b0;
    inc_cnt       = 1'b0;
    set_done      = 1'b0;
    set_start_err = 1'b0;
    set_tx_udr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          if (ctrl_q[13:12] == MODE_OFF || (!rw && tx_empty)) begin
            set_start_err = 1'b1;
          end else begin
            clr_cnt = 1'b1;
            state_d = RUN;
            if (!rw) begin
              tx_pop    = 1'b1;
              load_dout = 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (cmd_abort) begin
          state_d = IDLE;
        end else if (done_pulse) begin
          inc_cnt = 1'b1;
          if (rw) begin
            rx_push = 1'b1;
          end else if (cnt_next < {1'b0, cnt_q}) begin
            if (!tx_empty) begin
              tx_pop    = 1'b1;
              load_dout = 1'b1;
            end else begin
              set_tx_udr = 1'b1;
            end
          end
          if (cnt_next >= {1'b0, cnt_q}) state_d = DONE;
        end
      end
      DONE: begin
        set_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Interrupt flag set/clear vectors; a set in the same cycle beats W1C
  always_comb begin
    irq_set                = '0;
    irq_set[IRQ_DONE]      = set_done;
    irq_set[IRQ_TX_OVF]    = tx_push & tx_full & ~tx_pop;
    irq_set[IRQ_RX_OVF]    = rx_push & rx_full & ~rx_pop;
    irq_set[IRQ_TX_UDR]    = set_tx_udr;
    irq_set[IRQ_START_ERR] = set_start_err;
    irq_clr                = (wr_en && sel_irq) ? pwdata[IRQ_W-1:0] : '0;
  end

  // Configuration registers, flags and their core-facing copies
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q          <= '0;
      addr_q          <= '0;
      cnt_q           <= '0;
      irq_q           <= '0;
      irq_en_q        <= '0;
      tx_ctrl         <= '0;
      tx_apb_addr     <= '0;
      tx_apb_data_cnt <= '0;
      status_done_q   <= 1'b0;
    end else begin
      if (wr_en && !busy && sel_ctrl) ctrl_q <= pwdata[15:0];
      if (wr_en && !busy && sel_addr) addr_q <= pwdata[7:0];
      if (wr_en && !busy && sel_cnt)  cnt_q  <= pwdata[7:0];
      if (wr_en && sel_irq_en)        irq_en_q <= pwdata[IRQ_W-1:0];
      irq_q           <= (irq_q & ~irq_clr) | irq_set;
      tx_ctrl         <= ctrl_q;
      tx_apb_addr     <= addr_q;
      tx_apb_data_cnt <= cnt_q;
      status_done_q   <= status[STAT_I2C_DONE];
    end
  end

  // Sequencer state, byte counter and transmit byte register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      data_out_apb <= '0;
    end else begin
      state_q <= state_d;
      if (clr_cnt)        byte_cnt_q <= '0;
      else if (inc_cnt)   byte_cnt_q <= byte_cnt_q + 8'd1;
      if (load_dout)      data_out_apb <= tx_dout;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (pwdata[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (data_in_apb),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_apb_i2c_regs.sv
// Directed bench for apb_i2c_regs: APB register access, master write/read
// transfers, FIFO overflow/underrun, start errors, abort and reset.
module tb_apb_i2c_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        i_ready;
  logic [15:0] tx_ctrl;
  logic [7:0]  tx_apb_addr;
  logic [7:0]  tx_apb_data_cnt;
  logic [7:0]  data_out_apb;
  logic [7:0]  data_in_apb = '0;
  logic [7:0]  status = '0;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rdata;
  logic        err;
  logic        rdy;

  apb_i2c_regs #(.FIFO_DEPTH(4), .APB_AW(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .prdata          (prdata),
    .pready          (pready),
    .pslverr         (pslverr),
    .i_ready         (i_ready),
    .tx_ctrl         (tx_ctrl),
    .tx_apb_addr     (tx_apb_addr),
    .tx_apb_data_cnt (tx_apb_data_cnt),
    .data_out_apb    (data_out_apb),
    .data_in_apb     (data_in_apb),
    .status          (status),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    err = pslverr;
    rdy = pready;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    rdata = prdata;
    err   = pslverr;
    rdy   = pready;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // One rising edge on status[3] with the received byte on data_in_apb
  task automatic pulse_done(input logic [7:0] d);
    @(posedge clk); #1;
    data_in_apb = d;
    status[3]   = 1'b1;
    @(posedge clk); #1;
    status[3]   = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus", {prdata, pready, pslverr, i_ready, irq}, 36'h0);
    check("rst_core", {tx_ctrl, tx_apb_addr, tx_apb_data_cnt, data_out_apb}, 40'h0);
    rst = 1'b1;

    apb_read(8'h00); check("rst_ctrl", rdata, 32'h0); check("rst_pready", {31'h0, rdy}, 32'h1);
    apb_read(8'h04); check("rst_addr", rdata, 32'h0);
    apb_read(8'h08); check("rst_cnt", rdata, 32'h0);
    apb_read(8'h10); check("rst_rx_data", rdata, 32'h0); check("rst_rx_err", {31'h0, err}, 32'h1);
    status = 8'h05;
    apb_read(8'h14); check("rst_stat", rdata, 32'h5005);
    status = 8'h00;
    apb_read(8'h1C); check("rst_irq", rdata, 32'h0);
    apb_read(8'h20); check("rst_irq_en", rdata, 32'h0);
    apb_read(8'h24); check("unmapped_err", {31'h0, err}, 32'h1);
    apb_read(8'h00); check("mapped_no_err", {31'h0, err}, 32'h0);

    // Master write of two bytes
    apb_write(8'h00, 32'h2064);
    apb_write(8'h04, 32'hA0);
    apb_write(8'h08, 32'h2);
    apb_write(8'h20, 32'h1F);
    check("tx_ctrl_copy", {16'h0, tx_ctrl}, 32'h2064);
    check("tx_addr_copy", {24'h0, tx_apb_addr}, 32'hA0);
    check("tx_cnt_copy", {24'h0, tx_apb_data_cnt}, 32'h2);
    apb_read(8'h20); check("irq_en_rb", rdata, 32'h1F);
    apb_write(8'h0C, 32'h11);
    apb_write(8'h0C, 32'h22);
    apb_read(8'h14); check("stat_tx2", rdata, 32'h1000);
    apb_write(8'h18, 32'h1);
    check("mw_iready", {31'h0, i_ready}, 32'h1);
    check("mw_byte0", {24'h0, data_out_apb}, 32'h11);
    apb_read(8'h14); check("mw_stat_busy", rdata, 32'h1800);
    pulse_done(8'h00);
    check("mw_byte1", {24'h0, data_out_apb}, 32'h22);
    check("mw_iready_mid", {31'h0, i_ready}, 32'h1);
    pulse_done(8'h00);
    check("mw_iready_end", {31'h0, i_ready}, 32'h0);
    apb_read(8'h1C); check("mw_irq_done", rdata, 32'h01);
    check("mw_irq_pin", {31'h0, irq}, 32'h1);
    apb_write(8'h1C, 32'h01);
    apb_read(8'h1C); check("mw_irq_w1c", rdata, 32'h0);
    check("mw_irq_pin_clr", {31'h0, irq}, 32'h0);

    // Master read of three bytes, with a config write attempted while busy
    apb_write(8'h04, 32'hA1);
    apb_write(8'h08, 32'h3);
    apb_write(8'h18, 32'h1);
    check("mr_iready", {31'h0, i_ready}, 32'h1);
    apb_write(8'h00, 32'h1234);
    check("busy_ctrl_err", {31'h0, err}, 32'h1);
    pulse_done(8'h5A);
    pulse_done(8'h5B);
    pulse_done(8'h5C);
    check("mr_iready_end", {31'h0, i_ready}, 32'h0);
    apb_read(8'h00); check("busy_ctrl_kept", rdata, 32'h2064);
    apb_read(8'h1C); check("mr_irq_done", rdata, 32'h01);
    apb_read(8'h10); check("mr_rx0", rdata, 32'h5A); check("mr_rx0_err", {31'h0, err}, 32'h0);
    apb_read(8'h10); check("mr_rx1", rdata, 32'h5B);
    apb_read(8'h10); check("mr_rx2", rdata, 32'h5C);
    apb_read(8'h10); check("mr_rx3_data", rdata, 32'h0); check("mr_rx3_err", {31'h0, err}, 32'h1);
    apb_write(8'h1C, 32'h1F);

    // TX overflow, then TX underrun in a 6-byte write
    apb_write(8'h04, 32'hA0);
    apb_write(8'h0C, 32'h01);
    apb_write(8'h0C, 32'h02);
    apb_write(8'h0C, 32'h03);
    apb_write(8'h0C, 32'h04);
    apb_write(8'h0C, 32'h05);
    check("tx_ovf_no_err", {31'h0, err}, 32'h0);
    apb_read(8'h1C); check("tx_ovf_flag", rdata, 32'h02);
    apb_read(8'h14); check("tx_full_stat", rdata, 32'h9000);
    apb_write(8'h08, 32'h6);
    apb_write(8'h18, 32'h1);
    check("udr_byte0", {24'h0, data_out_apb}, 32'h01);
    pulse_done(8'h00);
    pulse_done(8'h00);
    pulse_done(8'h00);
    check("udr_byte3", {24'h0, data_out_apb}, 32'h04);
    apb_read(8'h1C); check("udr_not_yet", rdata, 32'h02);
    pulse_done(8'h00);
    apb_read(8'h1C); check("udr_flag", rdata, 32'h0A);
    check("udr_hold", {24'h0, data_out_apb}, 32'h04);
    pulse_done(8'h00);
    pulse_done(8'h00);
    apb_read(8'h1C); check("udr_done", rdata, 32'h0B);
    apb_write(8'h1C, 32'h1F);

    // RX overflow: five bytes into four slots
    apb_write(8'h04, 32'hA1);
    apb_write(8'h08, 32'h5);
    apb_write(8'h18, 32'h1);
    pulse_done(8'h60);
    pulse_done(8'h61);
    pulse_done(8'h62);
    pulse_done(8'h63);
    pulse_done(8'h64);
    apb_read(8'h1C); check("rx_ovf_flag", rdata, 32'h05);
    apb_read(8'h14); check("rx_full_stat", rdata, 32'h6000);
    apb_read(8'h10); check("rx_ovf_b0", rdata, 32'h60);
    apb_read(8'h10); check("rx_ovf_b1", rdata, 32'h61);
    apb_read(8'h10); check("rx_ovf_b2", rdata, 32'h62);
    apb_read(8'h10); check("rx_ovf_b3", rdata, 32'h63);
    apb_read(8'h10); check("rx_ovf_drained", {31'h0, err}, 32'h1);
    apb_write(8'h1C, 32'h1F);

    // START errors: mode 00, and write with empty TX FIFO
    apb_write(8'h00, 32'h0064);
    apb_write(8'h18, 32'h1);
    check("serr_mode_iready", {31'h0, i_ready}, 32'h0);
    apb_read(8'h1C); check("serr_mode_flag", rdata, 32'h10);
    apb_write(8'h1C, 32'h10);
    apb_write(8'h00, 32'h2064);
    apb_write(8'h04, 32'hA0);
    apb_write(8'h18, 32'h1);
    check("serr_txe_iready", {31'h0, i_ready}, 32'h0);
    apb_read(8'h1C); check("serr_txe_flag", rdata, 32'h10);
    apb_write(8'h1C, 32'h1F);

    // ABORT after the first of three read bytes
    apb_write(8'h04, 32'hA1);
    apb_write(8'h08, 32'h3);
    apb_write(8'h18, 32'h1);
    pulse_done(8'h77);
    check("abort_pre_iready", {31'h0, i_ready}, 32'h1);
    apb_write(8'h18, 32'h2);
    check("abort_iready", {31'h0, i_ready}, 32'h0);
    apb_read(8'h1C); check("abort_no_done", rdata, 32'h0);
    apb_read(8'h10); check("abort_rx_kept", rdata, 32'h77);
    apb_read(8'h14); check("abort_stat_idle", rdata, 32'h5000);

    // Reset asserted during RUN
    apb_write(8'h18, 32'h1);
    check("rstrun_iready", {31'h0, i_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstrun_bus", {prdata, pready, pslverr, i_ready, irq}, 36'h0);
    check("rstrun_core", {tx_ctrl, tx_apb_addr, tx_apb_data_cnt, data_out_apb}, 40'h0);
    rst = 1'b1;
    apb_read(8'h00); check("rstrun_ctrl", rdata, 32'h0);
    apb_read(8'h14); check("rstrun_stat", rdata, 32'h5000);
    apb_read(8'h1C); check("rstrun_irq", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
